// File: rtl/contador_pkg.sv
// Shared encodings for the 16-bit mode counter and its scoreboard checker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package contador_pkg;

    // Counter operating modes, as driven on MODO.
    typedef enum logic [1:0] {
        MODO_UP    = 2'b00,
        MODO_DOWN  = 2'b01,
        MODO_DOWN3 = 2'b10,
        MODO_LOAD  = 2'b11
    } modo_t;

    // Checker synchronisation state.
    typedef enum logic {
        ST_UNSYNC = 1'b0,
        ST_TRACK  = 1'b1
    } estado_t;

    // Step size of the fast down-count mode.
    localparam int DOWN3_STEP = 3;

    // True when the controls request a parallel load that the counter will honour.
    function automatic logic es_carga(input logic enb, input logic [1:0] modo);
        return enb && (modo_t'(modo) == MODO_LOAD);
    endfunction

endpackage

// File: rtl/modelo_contador.sv
// Reference model of the mode counter: next value and ripple-carry from the current value.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
module modelo_contador
    import contador_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             ENB,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] entrada,
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt,
    output logic             nxt_rco
);

    // One extra bit so the carry/borrow falls out of the arithmetic directly.
    localparam logic [WIDTH:0] PASO_UNO  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] PASO_TRES = (WIDTH+1)'(DOWN3_STEP);

    logic [WIDTH:0] ext_cur;
    logic [WIDTH:0] suma;

    assign ext_cur = {1'b0, cur};

    // Next value and carry/borrow for the selected mode; disabled counter holds with RCO low.
    always_comb begin
        suma    = '0;
        nxt     = cur;
        nxt_rco = 1'b0;
        if (ENB) begin
            case (modo_t'(MODO))
                MODO_UP: begin
                    suma    = ext_cur + PASO_UNO;
                    nxt     = suma[WIDTH-1:0];
                    nxt_rco = suma[WIDTH];
                end
                MODO_DOWN: begin
                    suma    = ext_cur - PASO_UNO;
                    nxt     = suma[WIDTH-1:0];
                    nxt_rco = suma[WIDTH];
                end
                MODO_DOWN3: begin
                    // Borrow out of bit WIDTH is set exactly when cur < 3.
                    suma    = ext_cur - PASO_TRES;
                    nxt     = suma[WIDTH-1:0];
                    nxt_rco = suma[WIDTH];
                end
                MODO_LOAD: begin
                    nxt     = entrada;
                    nxt_rco = 1'b0;
                end
                default: begin
                    nxt     = cur;
                    nxt_rco = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/verificador_contador.sv
// Scoreboard beside the mode counter: predicts salida/RCO, flags and counts mismatches, counts RCO pulses.
// Latency: prediction registered at edge n, compared at edge n+1; error/error_cnt update on that edge.
// Backpressure: none; observes every cycle. Optional mismatch capture ports with VERIFICADOR_CAPTURE_EN.
module verificador_contador
    import contador_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             ENB,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] entrada,
    input  logic [WIDTH-1:0] salida,
    input  logic             RCO,
    output logic             sync,
    output logic             error,
    output logic [CNT_W-1:0] error_cnt,
    output logic [CNT_W-1:0] wrap_cnt
`ifdef VERIFICADOR_CAPTURE_EN
    ,
    output logic [WIDTH-1:0] cap_exp,
    output logic [WIDTH-1:0] cap_obs,
    output logic             cap_valid
`endif
);

    localparam logic [CNT_W-1:0] CNT_UNO = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    estado_t          estado_q;
    logic [WIDTH-1:0] exp_q;
    logic             exp_rco_q;
    logic [WIDTH-1:0] pred_nxt;
    logic             pred_rco;
    logic             mismatch;

    // Prediction always runs from the model's own state, never from salida.
    modelo_contador #(
        .WIDTH (WIDTH)
    ) u_modelo (
        .ENB     (ENB),
        .MODO    (MODO),
        .entrada (entrada),
        .cur     (exp_q),
        .nxt     (pred_nxt),
        .nxt_rco (pred_rco)
    );

    // Only a tracking checker has a prediction worth comparing against.
    assign mismatch = (estado_q == ST_TRACK) &&
                      ((salida != exp_q) || (RCO != exp_rco_q));

    // Sync FSM and model state: wait for the first load, then follow the model every edge.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            estado_q  <= ST_UNSYNC;
            exp_q     <= '0;
            exp_rco_q <= 1'b0;
            sync      <= 1'b0;
        end else begin
            case (estado_q)
                ST_UNSYNC: begin
                    if (es_carga(ENB, MODO)) begin
                        exp_q     <= entrada;
                        exp_rco_q <= 1'b0;
                        estado_q  <= ST_TRACK;
                        sync      <= 1'b1;
                    end
                end
                ST_TRACK: begin
                    // A mismatch does not resync; only a load brings the model back in line.
                    exp_q     <= pred_nxt;
                    exp_rco_q <= pred_rco;
                    sync      <= 1'b1;
                end
                default: begin
                    estado_q <= ST_UNSYNC;
                    sync     <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flag and saturating mismatch count.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            error     <= 1'b0;
            error_cnt <= '0;
        end else if (mismatch) begin
            error <= 1'b1;
            if (error_cnt != CNT_MAX) begin
                error_cnt <= error_cnt + CNT_UNO;
            end
        end
    end

    // Every observed RCO pulse counts, tracking or not; rolls over freely.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            wrap_cnt <= '0;
        end else if (RCO) begin
            wrap_cnt <= wrap_cnt + CNT_UNO;
        end
    end

`ifdef VERIFICADOR_CAPTURE_EN
    // Freeze the expected/observed pair of the first mismatch since reset.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            cap_exp   <= '0;
            cap_obs   <= '0;
            cap_valid <= 1'b0;
        end else if (mismatch && !cap_valid) begin
            cap_exp   <= exp_q;
            cap_obs   <= salida;
            cap_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_verificador_contador.sv
// Directed vector bench for verificador_contador.
// Latency: rows driven after an edge, outputs checked 1 time unit after the next edge.
// Backpressure: n/a.
module tb_verificador_contador;

    logic        CLK;
    logic        RESET_L;
    logic        ENB;
    logic [1:0]  MODO;
    logic [15:0] entrada;
    logic [15:0] salida;
    logic        RCO;
    logic        sync;
    logic        error;
    logic [7:0]  error_cnt;
    logic [7:0]  wrap_cnt;
`ifdef VERIFICADOR_CAPTURE_EN
    logic [15:0] cap_exp;
    logic [15:0] cap_obs;
    logic        cap_valid;
`endif

    int n_vec;
    int n_err;

    verificador_contador #(
        .WIDTH (16),
        .CNT_W (8)
    ) dut (
        .CLK       (CLK),
        .RESET_L   (RESET_L),
        .ENB       (ENB),
        .MODO      (MODO),
        .entrada   (entrada),
        .salida    (salida),
        .RCO       (RCO),
        .sync      (sync),
        .error     (error),
        .error_cnt (error_cnt),
        .wrap_cnt  (wrap_cnt)
`ifdef VERIFICADOR_CAPTURE_EN
        ,
        .cap_exp   (cap_exp),
        .cap_obs   (cap_obs),
        .cap_valid (cap_valid)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        enb;
        logic [1:0]  modo;
        logic [15:0] ent;
        logic [15:0] sal;
        logic        rco;
        logic        x_sync;
        logic        x_err;
        logic [7:0]  x_ec;
        logic [7:0]  x_wc;
    } vec_t;

    vec_t tabla[$];

    function automatic void add(input logic enb, input logic [1:0] modo, input logic [15:0] ent,
                                input logic [15:0] sal, input logic rco, input logic x_sync,
                                input logic x_err, input logic [7:0] x_ec, input logic [7:0] x_wc);
        vec_t v;
        v.enb = enb; v.modo = modo; v.ent = ent; v.sal = sal; v.rco = rco;
        v.x_sync = x_sync; v.x_err = x_err; v.x_ec = x_ec; v.x_wc = x_wc;
        tabla.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic drive(input logic enb, input logic [1:0] modo, input logic [15:0] ent,
                         input logic [15:0] sal, input logic rco);
        ENB = enb; MODO = modo; entrada = ent; salida = sal; RCO = rco;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            drive(tabla[i].enb, tabla[i].modo, tabla[i].ent, tabla[i].sal, tabla[i].rco);
            @(posedge CLK);
            #1;
            chk($sformatf("row%0d_sync", i), {31'd0, sync},      {31'd0, tabla[i].x_sync});
            chk($sformatf("row%0d_err", i),  {31'd0, error},     {31'd0, tabla[i].x_err});
            chk($sformatf("row%0d_ecnt", i), {24'd0, error_cnt}, {24'd0, tabla[i].x_ec});
            chk($sformatf("row%0d_wcnt", i), {24'd0, wrap_cnt},  {24'd0, tabla[i].x_wc});
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_sync"}, {31'd0, sync},      32'd0);
        chk({pfx, "_err"},  {31'd0, error},     32'd0);
        chk({pfx, "_ecnt"}, {24'd0, error_cnt}, 32'd0);
        chk({pfx, "_wcnt"}, {24'd0, wrap_cnt},  32'd0);
`ifdef VERIFICADOR_CAPTURE_EN
        chk({pfx, "_capv"}, {31'd0, cap_valid}, 32'd0);
`endif
    endtask

    initial begin
        int n_a;
        int n_b;
        n_vec = 0;
        n_err = 0;

        // Part A: load 0, count up 0..15, wrap through FFFF, down-3 borrow, forced mismatch.
        add(1, 2'b11, 16'h0000, 16'h1234, 0, 1, 0, 8'd0, 8'd0);
        for (int k = 1; k <= 16; k++)
            add(1, 2'b00, 16'h0000, 16'(k - 1), 0, 1, 0, 8'd0, 8'd0);
        add(1, 2'b11, 16'hFFFE, 16'd16,   0, 1, 0, 8'd0, 8'd0);
        add(1, 2'b00, 16'h0000, 16'hFFFE, 0, 1, 0, 8'd0, 8'd0);
        add(1, 2'b00, 16'h0000, 16'hFFFF, 0, 1, 0, 8'd0, 8'd0);
        add(1, 2'b00, 16'h0000, 16'h0000, 1, 1, 0, 8'd0, 8'd1);
        add(1, 2'b00, 16'h0000, 16'h0001, 0, 1, 0, 8'd0, 8'd1);
        add(1, 2'b11, 16'h0001, 16'h0002, 0, 1, 0, 8'd0, 8'd1);
        add(1, 2'b10, 16'h0000, 16'h0001, 0, 1, 0, 8'd0, 8'd1);
        add(0, 2'b00, 16'h0000, 16'hFFFF, 1, 1, 1, 8'd1, 8'd2);
        add(0, 2'b00, 16'h0000, 16'hFFFE, 0, 1, 1, 8'd1, 8'd2);
        n_a = tabla.size();

        // Part B (after reset): unsynced bogus traffic, then resync and edge modes, then RCO-only mismatch.
        add(1, 2'b00, 16'h0000, 16'hAAAA, 1, 0, 0, 8'd0, 8'd1);
        add(1, 2'b01, 16'h0000, 16'h5555, 0, 0, 0, 8'd0, 8'd1);
        add(1, 2'b10, 16'h0000, 16'h0000, 1, 0, 0, 8'd0, 8'd2);
        add(0, 2'b11, 16'h0009, 16'h0001, 0, 0, 0, 8'd0, 8'd2);
        add(1, 2'b11, 16'h0005, 16'h0003, 0, 1, 0, 8'd0, 8'd2);
        add(1, 2'b01, 16'h0000, 16'h0005, 0, 1, 0, 8'd0, 8'd2);
        add(1, 2'b10, 16'h0000, 16'h0004, 0, 1, 0, 8'd0, 8'd2);
        add(1, 2'b11, 16'h0000, 16'h0001, 0, 1, 0, 8'd0, 8'd2);
        add(1, 2'b01, 16'h0000, 16'h0000, 0, 1, 0, 8'd0, 8'd2);
        add(1, 2'b00, 16'h0000, 16'hFFFF, 1, 1, 0, 8'd0, 8'd3);
        add(1, 2'b10, 16'h0000, 16'h0000, 1, 1, 0, 8'd0, 8'd4);
        add(0, 2'b00, 16'h0000, 16'hFFFD, 1, 1, 0, 8'd0, 8'd5);
        add(0, 2'b00, 16'h0000, 16'hFFFD, 1, 1, 1, 8'd1, 8'd6);
        n_b = tabla.size();

        // Reset state.
        RESET_L = 1'b0;
        drive(0, 2'b00, 16'h0000, 16'h0000, 0);
        repeat (3) @(posedge CLK);
        #1;
        chk_zero("reset");
        @(negedge CLK);
        RESET_L = 1'b1;

        run_rows(0, n_a);
`ifdef VERIFICADOR_CAPTURE_EN
        chk("cap_valid", {31'd0, cap_valid}, 32'd1);
        chk("cap_exp",   {16'd0, cap_exp},   32'h0000FFFE);
        chk("cap_obs",   {16'd0, cap_obs},   32'h0000FFFF);
`endif

        // Asynchronous reset between edges while tracking.
        #2;
        RESET_L = 1'b0;
        #1;
        chk_zero("async_rst");
        @(negedge CLK);
        RESET_L = 1'b1;

        run_rows(n_a, n_b);

        // Saturation: hold the model at 7 and present 8 every cycle.
        #2;
        RESET_L = 1'b0;
        #1;
        RESET_L = 1'b1;
        drive(1, 2'b11, 16'h0007, 16'h0000, 0);
        @(posedge CLK);
        #1;
        chk("sat_sync", {31'd0, sync}, 32'd1);
        for (int i = 1; i <= 300; i++) begin
            drive(0, 2'b00, 16'h0000, 16'h0008, 0);
            @(posedge CLK);
            #1;
            if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300) begin
                chk($sformatf("sat%0d_ecnt", i), {24'd0, error_cnt},
                    (i < 255) ? 32'(i) : 32'd255);
                chk($sformatf("sat%0d_err", i), {31'd0, error}, 32'd1);
            end
        end
        chk("sat_wcnt", {24'd0, wrap_cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
